// File: rtl/fib_seq_pkg.sv
// Shared types and constants for the Fibonacci run/stop/step sequencer.
// The timer width is derived from the step period.
package fib_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_PERIOD = 4;
   localparam int unsigned TIMER_WIDTH    = $clog2(DEFAULT_PERIOD);

   // Keeps the counter at least one bit wide even for degenerate periods.
   function automatic int unsigned timer_width(input int unsigned period);
      return (period < 2) ? 1 : $clog2(period);
   endfunction

endpackage

// File: rtl/fibonacci_sequencer_step_timer.sv
// Period counter for RUN pacing: counts 0..PERIOD-1 while enabled and
// raises tick_o during the PERIOD-1 cycle. A restart forces the count back to 0.
module step_timer
   import fib_seq_pkg::*;
#(
   parameter int unsigned PERIOD = DEFAULT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic enable_i,
   input  logic restart_i,
   output logic tick_o
);

   localparam int unsigned   TW   = timer_width(PERIOD);
   localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

   logic [TW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (restart_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/fibonacci_sequencer.sv
// Run/stop/single-step controller for the Fibonacci generator: paces steps,
// captures each new term into the display register and handles generator wrap.
module fibonacci_sequencer
   import fib_seq_pkg::*;
#(
   parameter int unsigned NUMBER_WIDTH     = 16,
   parameter int unsigned PERIOD           = DEFAULT_PERIOD,
   parameter int unsigned STEP_COUNT_WIDTH = 8,
   parameter bit          AUTO_RESTART     = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_start,
   input  logic                        cmd_stop,
   input  logic                        cmd_step,
   input  logic                        cmd_clear,
   input  logic [NUMBER_WIDTH-1:0]     fib_value,
   output logic                        fib_step,
   output logic                        fib_clear,
   output logic [NUMBER_WIDTH-1:0]     display_value,
   output logic [STEP_COUNT_WIDTH-1:0] step_count,
   output logic                        running,
   output logic                        wrapped
);

   state_e                      state_q, state_d;
   logic                        step_q, step_d;
   logic                        clear_q, clear_d;
   logic                        cap_q, cap_d;
   logic                        wrapped_q, wrapped_d;
   logic                        running_q;
   logic [NUMBER_WIDTH-1:0]     display_q, display_d;
   logic [STEP_COUNT_WIDTH-1:0] count_q, count_d;

   logic do_clear, do_stop, do_start, do_step;
   logic wrap, tick, timer_restart;

   // Only the highest-priority command acts: clear > stop > start > step.
   assign do_clear = cmd_clear;
   assign do_stop  = cmd_stop  && !cmd_clear;
   assign do_start = cmd_start && !cmd_stop && !cmd_clear;
   assign do_step  = cmd_step  && !cmd_start && !cmd_stop && !cmd_clear;

   // A smaller term after at least one capture means the generator overflowed.
   assign wrap = cap_q && (count_q != '0) && (fib_value < display_q);

   step_timer #(
      .PERIOD(PERIOD)
   ) u_step_timer (
      .clk      (clk),
      .rst      (rst),
      .enable_i (state_q == RUN),
      .restart_i(timer_restart),
      .tick_o   (tick)
   );

   always_comb begin
      // NOTE: every _d and strobe gets its hold/idle value first, so no path through this block can infer a latch.
      state_d       = state_q;
      step_d        = 1'b0;
      clear_d       = 1'b0;
      cap_d         = step_q;
      display_d     = display_q;
      count_d       = count_q;
      wrapped_d     = wrapped_q;
      timer_restart = 1'b0;

      if (cap_q && !wrap) begin
         display_d = fib_value;
         count_d   = count_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (do_start) begin
               state_d       = RUN;
               timer_restart = 1'b1;
            end else if (do_step && !step_q && !cap_q) begin
               step_d = 1'b1;
            end
         end
         RUN: begin
            if (do_stop) begin
               state_d = IDLE;
            end else if (tick) begin
               step_d = 1'b1;
            end
         end
         HALT:    ;
         default: state_d = IDLE;
      endcase

      if (wrap) begin
         wrapped_d = 1'b1;
         if (AUTO_RESTART) begin
            clear_d       = 1'b1;
            display_d     = '0;
            count_d       = '0;
            timer_restart = 1'b1;
         end else begin
            state_d = HALT;
         end
      end

      // Clear overrides everything above, including a capture about to land.
      if (do_clear) begin
         state_d       = (state_q == RUN) ? RUN : IDLE;
         step_d        = 1'b0;
         cap_d         = 1'b0;
         clear_d       = 1'b1;
         display_d     = '0;
         count_d       = '0;
         wrapped_d     = 1'b0;
         timer_restart = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every one samples the pre-edge values.
      if (rst) begin
         state_q   <= IDLE;
         step_q    <= 1'b0;
         clear_q   <= 1'b1;
         cap_q     <= 1'b0;
         display_q <= '0;
         count_q   <= '0;
         wrapped_q <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         clear_q   <= clear_d;
         cap_q     <= cap_d;
         display_q <= display_d;
         count_q   <= count_d;
         wrapped_q <= wrapped_d;
         running_q <= (state_d == RUN);
      end
   end

   assign fib_step      = step_q;
   assign fib_clear     = clear_q;
   assign display_value = display_q;
   assign step_count    = count_q;
   assign running       = running_q;
   assign wrapped       = wrapped_q;

endmodule
